// File: rtl/mdio_pkg.sv
// Shared MDIO clause-22 definitions for the station-side reader and writer.
package mdio_pkg;
  localparam logic [1:0] ST       = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam int PHY_AW         = 5;
  localparam int REG_AW         = 5;
  localparam int DATA_W         = 16;
  localparam int HDR_FIELD_BITS = 2 + 2 + PHY_AW + REG_AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA
  } mdio_reader_state_t;
endpackage

// File: rtl/mdio_clock_gen.sv
// Free-running MDC generator with one-clk strobes on the cycles where MDC falls or rises.
module mdio_clock_gen #(
  parameter int CLKS_PER_BIT = 125
) (
  input  logic clk,
  input  logic reset,
  output logic mdc_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);
  localparam int            CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mdc_q, mdc_d;
  logic          tc;

  always_comb begin
    tc    = (cnt_q == TC);
    cnt_d = tc ? '0 : cnt_q + 1'b1;
    mdc_d = tc ? ~mdc_q : mdc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

  // Strobes mark the cycle whose closing edge moves MDC.
  assign mdc_o      = mdc_q;
  assign rise_stb_o = tc & ~mdc_q;
  assign fall_stb_o = tc & mdc_q;
endmodule

// File: rtl/mdio_reader.sv
// Clause-22 MDIO read master: one read frame per accepted request, 16-bit result
// returned with a single-cycle rsp_valid pulse.
module mdio_reader
  import mdio_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 125,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_phy_addr,
  input  logic [4:0]  req_reg_addr,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_error,
  output logic        busy,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic        mdc
);
  localparam int HDR_W   = PREAMBLE_BITS + HDR_FIELD_BITS;
  localparam int CNT_MAX = (PREAMBLE_BITS > DATA_W) ? PREAMBLE_BITS : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [HDR_W-1:0] PRE_MASK = {HDR_W{1'b1}} << HDR_FIELD_BITS;

  logic rise_stb, fall_stb;

  mdio_clock_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_clk_gen (
    .clk        (clk),
    .reset      (reset),
    .mdc_o      (mdc),
    .rise_stb_o (rise_stb),
    .fall_stb_o (fall_stb)
  );

  mdio_reader_state_t  state_q, state_d;
  logic [HDR_W-1:0]    hdr_q, hdr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   cap_q, cap_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                mdo_q, mdo_d;
  logic                mdt_q, mdt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_error_q, rsp_error_d;
  logic                ta_err_q, ta_err_d;
  logic                busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    mdo_d       = mdo_q;
    mdt_d       = mdt_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    ta_err_d    = ta_err_q;
    busy_d      = busy_q;
    // busy_q is still set during the rsp_valid cycle, which keeps req_ready low there
    req_ready   = (state_q == S_IDLE) && !busy_q;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (req_valid && req_ready) begin
          hdr_d   = PRE_MASK | HDR_W'({ST, OP_READ, req_phy_addr, req_reg_addr});
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = (PREAMBLE_BITS > 0) ? S_PRE : S_HDR;
        end
      end
      S_PRE: begin
        if (fall_stb) begin
          mdo_d = hdr_q[HDR_W-1];
          mdt_d = 1'b0;
          hdr_d = {hdr_q[HDR_W-2:0], 1'b0};
          if (cnt_q == CNT_W'(PREAMBLE_BITS - 1)) begin
            cnt_d   = '0;
            state_d = S_HDR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_HDR: begin
        if (fall_stb) begin
          if (cnt_q == CNT_W'(HDR_FIELD_BITS)) begin
            // This fall opens TA bit 1: hand the line to the PHY
            mdo_d   = 1'b1;
            mdt_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_TA;
          end else begin
            mdo_d = hdr_q[HDR_W-1];
            mdt_d = 1'b0;
            hdr_d = {hdr_q[HDR_W-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_TA: begin
        if (rise_stb && cnt_q == CNT_W'(1)) ta_err_d = mdio_i;
        if (fall_stb) begin
          if (cnt_q == CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = S_DATA;
          end else begin
            cnt_d = CNT_W'(1);
          end
        end
      end
      S_DATA: begin
        if (rise_stb) begin
          cap_d = {cap_q[DATA_W-2:0], mdio_i};
          cnt_d = cnt_q + 1'b1;
        end
        if (fall_stb && cnt_q == CNT_W'(DATA_W)) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = cap_q;
          rsp_error_d = ta_err_q;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hdr_q       <= '0;
      cnt_q       <= '0;
      cap_q       <= '0;
      mdo_q       <= 1'b1;
      mdt_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      ta_err_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      mdo_q       <= mdo_d;
      mdt_q       <= mdt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      ta_err_q    <= ta_err_d;
      busy_q      <= busy_d;
    end
  end

  assign mdio_o    = mdo_q;
  assign mdio_t    = mdt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;
  assign busy      = busy_q;
endmodule
